// File: rtl/turbo_iter_ctrl_if.sv
// turbo_iter_ctrl_if
//   Bundles the symbol-input handshake, the SISO launch/result bus and the
//   decoded-bit output handshake of turbo_iter_ctrl.
//   slave  : decoder side (turbo_iter_ctrl)
//   master : environment side (symbol source, SISO engine, bit sink)
//   Signals:
//     in_valid_i/in_ready_o, in_sys_i/in_par1_i/in_par2_i  input symbols (signed LLRs)
//     siso_start_o/siso_done_i                            SISO launch / completion
//     siso_sys_o/siso_par_o/siso_apri_o, siso_app_i       SISO data, symbol 0 in MSBs
//     out_valid_o/out_ready_i, out_bit_o/out_last_o       decoded bits
//     iter_cnt_o, busy_o                                  status
interface turbo_iter_ctrl_if #(
  parameter int K        = 5,
  parameter int N_TAIL   = 2,
  parameter int LLR_W    = 4,
  parameter int EXT_W    = 10,
  parameter int MAX_ITER = 16
);
  localparam int N  = K + N_TAIL;
  localparam int CW = $clog2(MAX_ITER + 1);

  logic               in_valid_i;
  logic               in_ready_o;
  logic [LLR_W-1:0]   in_sys_i;
  logic [LLR_W-1:0]   in_par1_i;
  logic [LLR_W-1:0]   in_par2_i;
  logic               siso_start_o;
  logic               siso_done_i;
  logic [N*LLR_W-1:0] siso_sys_o;
  logic [N*LLR_W-1:0] siso_par_o;
  logic [N*EXT_W-1:0] siso_apri_o;
  logic [N*EXT_W-1:0] siso_app_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic               out_bit_o;
  logic               out_last_o;
  logic [CW-1:0]      iter_cnt_o;
  logic               busy_o;

  modport slave (
    input  in_valid_i, in_sys_i, in_par1_i, in_par2_i, siso_done_i, siso_app_i, out_ready_i,
    output in_ready_o, siso_start_o, siso_sys_o, siso_par_o, siso_apri_o,
           out_valid_o, out_bit_o, out_last_o, iter_cnt_o, busy_o
  );

  modport master (
    output in_valid_i, in_sys_i, in_par1_i, in_par2_i, siso_done_i, siso_app_i, out_ready_i,
    input  in_ready_o, siso_start_o, siso_sys_o, siso_par_o, siso_apri_o,
           out_valid_o, out_bit_o, out_last_o, iter_cnt_o, busy_o
  );
endinterface

// File: rtl/turbo_iter_ctrl.sv
// turbo_iter_ctrl
//   Iteration controller for a two-constituent turbo decoder that time-shares
//   one external SISO engine. Loads one block of N = K+N_TAIL symbols, runs
//   DEC1/DEC2 half-iterations exchanging saturated extrinsic LLRs through the
//   interleaver pi(j) = (P_INTLV*j) mod K, stops early when hard decisions
//   repeat (or at MAX_ITER), then streams the K decoded bits.
//   Ports:
//     clk_p_i    clock
//     reset_n_i  asynchronous active-low reset
//     bus        turbo_iter_ctrl_if.slave (symbol in, SISO bus, bit out, status)
//
//   state | meaning
//   IDLE  | waiting for symbol 0 of a block
//   LOAD  | receiving symbols 1..N-1
//   DEC1  | SISO running on natural order, parity 1
//   DEC2  | SISO running on interleaved order, parity 2
//   OUT   | streaming decoded bits 0..K-1
module turbo_iter_ctrl #(
  parameter int K        = 5,
  parameter int N_TAIL   = 2,
  parameter int LLR_W    = 4,
  parameter int EXT_W    = 10,
  parameter int MAX_ITER = 16,
  parameter int P_INTLV  = 3
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  turbo_iter_ctrl_if.slave  bus
);
  localparam int N  = K + N_TAIL;
  localparam int CW = $clog2(MAX_ITER + 1);
  localparam int SW = $clog2(N);
  localparam int KW = $clog2(K);
  localparam int XW = EXT_W + 2;
  localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (EXT_W - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = XW'(-(1 << (EXT_W - 1)));

  typedef enum logic [2:0] {IDLE, LOAD, DEC1, DEC2, OUT} state_t;

  function automatic logic signed [XW-1:0] sx_e(input logic [EXT_W-1:0] v);
    sx_e = {{(XW-EXT_W){v[EXT_W-1]}}, v};
  endfunction

  function automatic logic signed [XW-1:0] sx_l(input logic [LLR_W-1:0] v);
    sx_l = {{(XW-LLR_W){v[LLR_W-1]}}, v};
  endfunction

  function automatic logic [EXT_W-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[EXT_W-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[EXT_W-1:0];
    else                  sat = v[EXT_W-1:0];
  endfunction

  function automatic int pi(input int j);
    pi = (P_INTLV * j) % K;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [LLR_W-1:0]   r_sys  [N];
  logic [LLR_W-1:0]   r_par1 [N];
  logic [LLR_W-1:0]   r_par2 [N];
  logic [EXT_W-1:0]   r_ext1 [N];
  logic [EXT_W-1:0]   r_ext2 [N];
  logic [SW-1:0]      r_sym_idx;
  logic [KW-1:0]      r_out_idx;
  logic [CW-1:0]      r_iter;
  logic [K-1:0]       r_bits;
  logic               r_start;

  logic [LLR_W-1:0]      w_sys      [N];
  logic [LLR_W-1:0]      w_par      [N];
  logic [EXT_W-1:0]      w_apri     [N];
  logic [EXT_W-1:0]      w_app      [N];
  logic signed [XW-1:0]  w_diff     [N];
  logic [EXT_W-1:0]      w_ext_new  [N];
  logic [EXT_W-1:0]      w_ext2_upd [N];
  logic signed [XW-1:0]  w_soft     [K];
  logic [K-1:0]          w_dec;
  logic [CW-1:0]         w_iter_inc;
  logic                  w_acc, w_done, w_xfer, w_last, w_stop;

  assign w_acc      = bus.in_valid_i && bus.in_ready_o;
  // a done coinciding with the launch pulse belongs to no live SISO run
  assign w_done     = bus.siso_done_i && !r_start && (r_state == DEC1 || r_state == DEC2);
  assign w_xfer     = (r_state == OUT) && bus.out_ready_i;
  assign w_last     = (r_out_idx == KW'(K - 1));
  assign w_iter_inc = r_iter + CW'(1);
  assign w_stop     = (w_iter_inc == CW'(MAX_ITER)) ||
                      ((w_iter_inc >= CW'(2)) && (w_dec == r_bits));

  // SISO view of the block; DEC2 reads systematic and ext1 through pi()
  always_comb begin
    bus.siso_sys_o  = '0;
    bus.siso_par_o  = '0;
    bus.siso_apri_o = '0;
    for (int p = 0; p < N; p++) begin
      w_app[p] = bus.siso_app_i[(N-1-p)*EXT_W +: EXT_W];
      if (p < K) begin
        if (r_state == DEC2) begin
          w_sys[p]  = r_sys[pi(p)];
          w_par[p]  = r_par2[p];
          w_apri[p] = r_ext1[pi(p)];
        end else begin
          w_sys[p]  = r_sys[p];
          w_par[p]  = r_par1[p];
          w_apri[p] = r_ext2[p];
        end
        w_diff[p] = sx_e(w_app[p]) - sx_e(w_apri[p]) - (sx_l(w_sys[p]) <<< 1);
      end else begin
        w_sys[p]  = r_sys[p];
        w_par[p]  = (r_state == DEC2) ? r_par2[p] : r_par1[p];
        w_apri[p] = '0;
        w_diff[p] = sx_e(w_app[p]);
      end
      w_ext_new[p] = sat(w_diff[p]);
      bus.siso_sys_o [(N-1-p)*LLR_W +: LLR_W] = w_sys[p];
      bus.siso_par_o [(N-1-p)*LLR_W +: LLR_W] = w_par[p];
      bus.siso_apri_o[(N-1-p)*EXT_W +: EXT_W] = w_apri[p];
    end
  end

  // ext2 as it will be after this DEC2, used for the decision in the same cycle
  always_comb begin
    w_ext2_upd = r_ext2;
    for (int j = 0; j < K; j++) w_ext2_upd[pi(j)] = w_ext_new[j];
    for (int i = 0; i < K; i++) begin
      w_soft[i] = (sx_l(r_sys[i]) <<< 1) + sx_e(r_ext1[i]) + sx_e(w_ext2_upd[i]);
      w_dec[i]  = w_soft[i][XW-1];
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.in_ready_o  = (r_state == IDLE) || (r_state == LOAD);
    bus.busy_o      = (r_state != IDLE);
    bus.out_valid_o = (r_state == OUT);
    bus.out_bit_o   = 1'b0;
    bus.out_last_o  = 1'b0;
    if (r_state == OUT) begin
      bus.out_bit_o  = r_bits[r_out_idx];
      bus.out_last_o = w_last;
    end
    unique case (r_state)
      IDLE:    if (w_acc) w_state_nxt = LOAD;
      LOAD:    if (w_acc && r_sym_idx == SW'(N - 1)) w_state_nxt = DEC1;
      DEC1:    if (w_done) w_state_nxt = DEC2;
      DEC2:    if (w_done) w_state_nxt = w_stop ? OUT : DEC1;
      OUT:     if (w_xfer && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.siso_start_o = r_start;
  assign bus.iter_cnt_o   = r_iter;

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int p = 0; p < N; p++) begin
        r_sys[p]  <= '0;
        r_par1[p] <= '0;
        r_par2[p] <= '0;
        r_ext1[p] <= '0;
        r_ext2[p] <= '0;
      end
      r_sym_idx <= '0;
      r_out_idx <= '0;
      r_iter    <= '0;
      r_bits    <= '0;
      r_start   <= 1'b0;
    end else begin
      r_start <= (w_state_nxt != r_state) && (w_state_nxt == DEC1 || w_state_nxt == DEC2);
      unique case (r_state)
        IDLE: if (w_acc) begin
          r_sys[0]  <= bus.in_sys_i;
          r_par1[0] <= bus.in_par1_i;
          r_par2[0] <= bus.in_par2_i;
          r_sym_idx <= SW'(1);
          r_iter    <= '0;
          for (int p = 0; p < N; p++) begin
            r_ext1[p] <= '0;
            r_ext2[p] <= '0;
          end
        end
        LOAD: if (w_acc) begin
          r_sys[r_sym_idx]  <= bus.in_sys_i;
          r_par1[r_sym_idx] <= bus.in_par1_i;
          r_par2[r_sym_idx] <= bus.in_par2_i;
          r_sym_idx         <= r_sym_idx + SW'(1);
        end
        DEC1: if (w_done) begin
          for (int p = 0; p < N; p++) r_ext1[p] <= w_ext_new[p];
        end
        DEC2: if (w_done) begin
          r_ext2    <= w_ext2_upd;
          r_iter    <= w_iter_inc;
          r_bits    <= w_dec;
          r_out_idx <= '0;
        end
        OUT: if (w_xfer) r_out_idx <= w_last ? '0 : r_out_idx + KW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: doc/turbo_iter_ctrl.md
TURBO_ITER_CTRL -- requirements
Module: turbo_iter_ctrl

Interface
REQ-001 SHALL have parameter K, default 5: information symbols per block, at least 2.
REQ-002 SHALL have parameter N_TAIL, default 2: termination symbols appended per block.
REQ-003 SHALL have parameter LLR_W, default 4: signed channel LLR width.
REQ-004 SHALL have parameter EXT_W, default 10: signed extrinsic/APP width, greater than LLR_W+1.
REQ-005 SHALL have parameter MAX_ITER, default 16: full-iteration cap, at least 2.
REQ-006 SHALL have parameter P_INTLV, default 3: interleaver multiplier, coprime with K; pi(j) = (P_INTLV*j) mod K.
REQ-007 SHALL define N = K+N_TAIL.
REQ-008 clk_p_i  in  1  clock; the block has one clock.
REQ-009 reset_n_i  in  1  asynchronous, active-low reset.
REQ-010 in_valid_i / in_ready_o  in/out  1  input symbol handshake.
REQ-011 in_sys_i, in_par1_i, in_par2_i  in  LLR_W each  signed systematic, parity-1 and parity-2 LLRs.
REQ-012 siso_start_o  out  1  one-cycle SISO launch pulse.
REQ-013 siso_done_i  in  1  SISO completion pulse.
REQ-014 siso_sys_o, siso_par_o  out  N*LLR_W  SISO inputs, symbol 0 in MSBs.
REQ-015 siso_apri_o  out  N*EXT_W  a-priori LLRs to the SISO.
REQ-016 siso_app_i  in  N*EXT_W  APP LLRs from the SISO.
REQ-017 out_valid_o / out_ready_i  out/in  1  decoded-bit handshake.
REQ-018 out_bit_o, out_last_o  out  1 each  decoded bit; last bit of block.
REQ-019 iter_cnt_o  out  clog2(MAX_ITER+1)  iterations used.
REQ-020 busy_o  out  1  high in every state except IDLE.

Function
REQ-021 SHALL use FSM states IDLE, LOAD, DEC1, DEC2, OUT.
REQ-022 in_ready_o SHALL be 1 only in IDLE and LOAD; a beat is accepted when in_valid_i && in_ready_o.
REQ-023 IDLE: on an accepted beat, store it as symbol 0, clear both extrinsic arrays and the iteration count, and go to LOAD.
REQ-024 LOAD: store symbols 1..N-1 in order; when symbol N-1 is accepted, go to DEC1.
REQ-025 siso_start_o SHALL pulse for exactly one cycle, on the first cycle of each DEC1/DEC2 entry.
REQ-026 siso_done_i SHALL be ignored outside DEC1/DEC2 and on the same cycle as siso_start_o.
REQ-027 DEC1 SISO inputs: sys[i], par1[i], apri[i] = ext2[i] for i < K; apri = 0 for tail positions.
REQ-028 DEC1 on siso_done_i: ext1[i] = sat(app[i] - apri[i] - 2*sys[i]) for i < K; tail ext1 = sat(app - apri); then go to DEC2.
REQ-029 DEC2 SISO inputs: position j < K drives sys[pi(j)], par2[j], apri = ext1[pi(j)]; tail positions drive sys/par2 of the tail and apri = 0.
REQ-030 DEC2 on siso_done_i: ext2[pi(j)] = sat(app[j] - apri[j] - 2*sys[pi(j)]); increment the iteration count.
REQ-031 Hard decision SHALL be bit[i] = 1 iff 2*sys[i] + ext1[i] + ext2[i] < 0, computed at the end of each DEC2.
REQ-032 Termination: after DEC2, go to OUT if iteration count = MAX_ITER, or if count >= 2 and the decisions equal the previous iteration's; otherwise go to DEC1.
REQ-033 sat() SHALL clamp to [-2^(EXT_W-1), 2^(EXT_W-1)-1], with intermediates at least EXT_W+2 bits wide; wrapping is forbidden.
REQ-034 OUT: present bits 0..K-1 in order with out_valid_o=1; advance only on out_valid_o && out_ready_i.
REQ-035 OUT: out_bit_o and out_last_o SHALL be held stable while out_ready_i is low; out_last_o=1 on bit K-1.
REQ-036 After the last bit is transferred, go to IDLE.
REQ-037 iter_cnt_o SHALL hold the final iteration count until the next block starts.

Reset
REQ-038 While reset_n_i=0: state=IDLE, all counters and arrays 0, siso_start_o=0, out_valid_o=0, out_bit_o=0, out_last_o=0, iter_cnt_o=0, busy_o=0, in_ready_o=1.
REQ-039 Reset asserted in any state SHALL abort the block; no output beat is produced for it.

Verification
REQ-040 Reset: assert reset mid-LOAD -> all outputs at REQ-038 values within the same cycle; in_ready_o=1 after release.
REQ-041 K=5, all symbols sys=par=+7, SISO model app = 2*sys+apri+8 -> early stop, iter_cnt_o=2, bits 0,0,0,0,0, out_last_o on the 5th bit.
REQ-042 SISO model flips the sign of info APPs every iteration -> iter_cnt_o=16, exactly 32 siso_start_o pulses.
REQ-043 Saturation: app=511, apri=-512, sys=0 -> ext=511; app=-512, apri=511 -> ext=-512.
REQ-044 Backpressure: out_ready_i low for 3 cycles on bit 2 -> bit 2 held, no bit lost or duplicated, 5 beats total.
REQ-045 Interleaver: K=5, P_INTLV=3, sys=i -> DEC2 siso_sys_o order 0,3,1,4,2; stray siso_done_i in LOAD is ignored.
